// File: rtl/rvv_backend_pkg.sv
// Shared vector-backend types and sizes used by the retire stage and its neighbours.
package rvv_backend_pkg;

    localparam int NUM_RT_UOP = 4;
    localparam int VLENB      = 16;
    localparam int VLEN       = VLENB * 8;

    typedef enum logic [1:0] {
        NOT_CHANGE    = 2'd0,
        BODY_ACTIVE   = 2'd1,
        BODY_INACTIVE = 2'd2,
        TAIL          = 2'd3
    } byte_type_e;

    typedef enum logic {
        VRF = 1'b0,
        XRF = 1'b1
    } w_type_e;

    typedef struct packed {
        logic [7:0] vstart;
        logic [7:0] vl;
        logic [1:0] vxrm;
        logic       vma;
        logic       vta;
        logic [2:0] sew;
        logic [2:0] lmul;
    } RVVCSR_t;

    typedef struct packed {
        logic                        w_valid;
        logic [4:0]                  w_index;
        logic [VLEN-1:0]             w_data;
        w_type_e                     w_type;
        byte_type_e [VLENB-1:0]      vd_type;
        logic                        trap_flag;
        RVVCSR_t                     vector_csr;
        logic                        vxsat;
        logic                        ignore_vta;
        logic                        ignore_vma;
        logic                        last_uop_valid;
    } ROB2RT_t;

    typedef struct packed {
        logic [4:0]       rt_index;
        logic [VLEN-1:0]  rt_data;
        logic [VLENB-1:0] rt_strobe;
    } RT2VRF_t;

    typedef struct packed {
        logic [4:0]  rt_index;
        logic [31:0] rt_data;
    } RT2XRF_t;

endpackage

// File: rtl/rvv_backend_retire_strobe.sv
// Per-lane byte write-enable generation from the destination byte types.
module rvv_backend_retire_strobe
    import rvv_backend_pkg::*;
(
    input  byte_type_e [VLENB-1:0] vd_type,
    input  logic                   ignore_vta,
    input  logic                   ignore_vma,
    output logic [VLENB-1:0]       strobe
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        strobe = '0;
        for (int b = 0; b < VLENB; b++) begin
            case (vd_type[b])
                BODY_ACTIVE:   strobe[b] = 1'b1;
                TAIL:          strobe[b] = ignore_vta;
                BODY_INACTIVE: strobe[b] = ignore_vma;
                default:       strobe[b] = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/rvv_backend_retire.sv
// Retire stage: accepts an in-order prefix of ROB uops, merges same-register
// strobes and holds the resulting VRF/XRF writes in a single output stage.
module rvv_backend_retire
    import rvv_backend_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RT_UOP-1:0]      rd_valid_rob2rt,
    input  ROB2RT_t [NUM_RT_UOP-1:0]   rd_rob2rt,
    output logic [NUM_RT_UOP-1:0]      rd_ready_rt2rob,
    output logic [NUM_RT_UOP-1:0]      wr_valid_rt2vrf,
    output RT2VRF_t [NUM_RT_UOP-1:0]   wr_rt2vrf,
    input  logic                       wr_ready_vrf2rt,
    output logic                       wr_valid_rt2xrf,
    output RT2XRF_t                    wr_rt2xrf,
    input  logic                       wr_ready_xrf2rt,
    output logic                       vcsr_valid_rt2csr,
    output RVVCSR_t                    vcsr_rt2csr,
    output logic                       vxsat_valid_rt2csr,
    output logic                       trap_done_rvv2rvs
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_TRAP = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [NUM_RT_UOP-1:0]     vrf_valid_q, vrf_valid_d;
    RT2VRF_t [NUM_RT_UOP-1:0]  vrf_q, vrf_d;
    logic                      xrf_valid_q, xrf_valid_d;
    RT2XRF_t                   xrf_q, xrf_d;
    logic                      vxsat_q, vxsat_d;
    logic                      vcsr_valid_q, vcsr_valid_d;
    RVVCSR_t                   vcsr_q, vcsr_d;

    logic                      drain;
    logic                      accept_open;
    logic                      trap_accept;
    logic                      xrf_wr;
    logic [NUM_RT_UOP-1:0]     ready;
    logic [NUM_RT_UOP-1:0]     accept;
    logic [NUM_RT_UOP-1:0]     vrf_wr;
    logic [VLENB-1:0]          raw_strobe    [NUM_RT_UOP];
    logic [VLENB-1:0]          merged_strobe [NUM_RT_UOP];

    for (genvar i = 0; i < NUM_RT_UOP; i++) begin : g_strobe
        rvv_backend_retire_strobe u_strobe (
            .vd_type    (rd_rob2rt[i].vd_type),
            .ignore_vta (rd_rob2rt[i].ignore_vta),
            .ignore_vma (rd_rob2rt[i].ignore_vma),
            .strobe     (raw_strobe[i])
        );
    end

    // The stage frees up this cycle when every pending write is taken, or none is pending.
    always_comb begin
        drain = (~|vrf_valid_q | wr_ready_vrf2rt) & (~xrf_valid_q | wr_ready_xrf2rt);
        // NOTE: rst_n gates ready combinationally so the ROB sees 0 for the whole reset, not just after an edge.
        accept_open = rst_n & (state_q != ST_TRAP) & drain;
    end

    // Ready chains lane by lane: a trap or an XRF uop ends the accepted prefix.
    always_comb begin
        ready    = '0;
        ready[0] = accept_open;
        for (int i = 1; i < NUM_RT_UOP; i++) begin
            ready[i] = ready[i-1] & rd_valid_rob2rt[i-1] & ~rd_rob2rt[i-1].trap_flag
                     & (rd_rob2rt[i-1].w_type != XRF) & (rd_rob2rt[i].w_type != XRF);
        end
    end

    always_comb begin
        accept      = ready & rd_valid_rob2rt;
        trap_accept = 1'b0;
        vrf_wr      = '0;
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            trap_accept |= accept[i] & rd_rob2rt[i].trap_flag;
            vrf_wr[i]    = accept[i] & rd_rob2rt[i].w_valid & ~rd_rob2rt[i].trap_flag
                         & (rd_rob2rt[i].w_type == VRF);
        end
        xrf_wr = accept[0] & rd_rob2rt[0].w_valid & ~rd_rob2rt[0].trap_flag
               & (rd_rob2rt[0].w_type == XRF);
    end

    // Younger lanes win on overlapping bytes of the same register.
    always_comb begin
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            merged_strobe[i] = raw_strobe[i];
            for (int j = i + 1; j < NUM_RT_UOP; j++) begin
                if (vrf_wr[i] && vrf_wr[j] && (rd_rob2rt[i].w_index == rd_rob2rt[j].w_index)) begin
                    merged_strobe[i] = merged_strobe[i] & ~raw_strobe[j];
                end
            end
        end
    end

    always_comb begin
        vrf_valid_d = vrf_valid_q;
        vrf_d       = vrf_q;
        xrf_valid_d = xrf_valid_q;
        xrf_d       = xrf_q;
        if (drain) begin
            vrf_valid_d = vrf_wr;
            for (int i = 0; i < NUM_RT_UOP; i++) begin
                vrf_d[i].rt_index  = rd_rob2rt[i].w_index;
                vrf_d[i].rt_data   = rd_rob2rt[i].w_data;
                vrf_d[i].rt_strobe = merged_strobe[i];
            end
            xrf_valid_d       = xrf_wr;
            xrf_d.rt_index    = rd_rob2rt[0].w_index;
            xrf_d.rt_data     = rd_rob2rt[0].w_data[31:0];
        end
    end

    // CSR pulses follow acceptance directly and never wait on the write stage.
    always_comb begin
        vxsat_d      = 1'b0;
        vcsr_valid_d = 1'b0;
        vcsr_d       = vcsr_q;
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            if (accept[i] && rd_rob2rt[i].w_valid && rd_rob2rt[i].vxsat) begin
                vxsat_d = 1'b1;
            end
            if (accept[i] && rd_rob2rt[i].last_uop_valid) begin
                vcsr_valid_d = 1'b1;
                vcsr_d       = rd_rob2rt[i].vector_csr;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        trap_done_rvv2rvs = 1'b0;
        case (state_q)
            ST_TRAP: begin
                if (drain) begin
                    state_d           = ST_IDLE;
                    trap_done_rvv2rvs = 1'b1;
                end
            end
            default: begin
                if (trap_accept) begin
                    state_d = ST_TRAP;
                end else if (|accept) begin
                    state_d = ST_BUSY;
                end else if (drain) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // NOTE: the stage payload is reset too, so nothing stale is visible on the write ports after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vrf_valid_q  <= '0;
            vrf_q        <= '0;
            xrf_valid_q  <= 1'b0;
            xrf_q        <= '0;
            vxsat_q      <= 1'b0;
            vcsr_valid_q <= 1'b0;
            vcsr_q       <= '0;
        end else begin
            state_q      <= state_d;
            vrf_valid_q  <= vrf_valid_d;
            vrf_q        <= vrf_d;
            xrf_valid_q  <= xrf_valid_d;
            xrf_q        <= xrf_d;
            vxsat_q      <= vxsat_d;
            vcsr_valid_q <= vcsr_valid_d;
            vcsr_q       <= vcsr_d;
        end
    end

    assign rd_ready_rt2rob    = ready;
    assign wr_valid_rt2vrf    = vrf_valid_q;
    assign wr_rt2vrf          = vrf_q;
    assign wr_valid_rt2xrf    = xrf_valid_q;
    assign wr_rt2xrf          = xrf_q;
    assign vxsat_valid_rt2csr = vxsat_q;
    assign vcsr_valid_rt2csr  = vcsr_valid_q;
    assign vcsr_rt2csr        = vcsr_q;

endmodule

// File: tb/tb_rvv_backend_retire.sv
// Bench for rvv_backend_retire: directed scenarios plus random traffic against a transaction-level model.
module tb_rvv_backend_retire;
    import rvv_backend_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_RT_UOP-1:0]    rd_valid = '0;
    ROB2RT_t [NUM_RT_UOP-1:0] rob = '0;
    logic [NUM_RT_UOP-1:0]    rd_ready;
    logic [NUM_RT_UOP-1:0]    wr_valid_rt2vrf;
    RT2VRF_t [NUM_RT_UOP-1:0] wr_rt2vrf;
    logic                     wr_ready_vrf = 1'b1;
    logic                     wr_valid_rt2xrf;
    RT2XRF_t                  wr_rt2xrf;
    logic                     wr_ready_xrf = 1'b1;
    logic                     vcsr_valid_rt2csr;
    RVVCSR_t                  vcsr_rt2csr;
    logic                     vxsat_valid_rt2csr;
    logic                     trap_done_rvv2rvs;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    logic [NUM_RT_UOP-1:0] last_ready;

    // Reference model state: what the write ports should show and whether a trap is pending.
    bit                       m_trap;
    logic [NUM_RT_UOP-1:0]    m_vv;
    RT2VRF_t [NUM_RT_UOP-1:0] m_v;
    bit                       m_xv;
    RT2XRF_t                  m_x;
    bit                       m_vxsat;
    bit                       m_vcsr_v;
    RVVCSR_t                  m_vcsr;

    rvv_backend_retire dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rd_valid_rob2rt    (rd_valid),
        .rd_rob2rt          (rob),
        .rd_ready_rt2rob    (rd_ready),
        .wr_valid_rt2vrf    (wr_valid_rt2vrf),
        .wr_rt2vrf          (wr_rt2vrf),
        .wr_ready_vrf2rt    (wr_ready_vrf),
        .wr_valid_rt2xrf    (wr_valid_rt2xrf),
        .wr_rt2xrf          (wr_rt2xrf),
        .wr_ready_xrf2rt    (wr_ready_xrf),
        .vcsr_valid_rt2csr  (vcsr_valid_rt2csr),
        .vcsr_rt2csr        (vcsr_rt2csr),
        .vxsat_valid_rt2csr (vxsat_valid_rt2csr),
        .trap_done_rvv2rvs  (trap_done_rvv2rvs)
    );

    always #5 clk = ~clk;

    function automatic logic [VLENB-1:0] strobe_of(input ROB2RT_t u);
        logic [VLENB-1:0] s;
        s = '0;
        for (int b = 0; b < VLENB; b++) begin
            s[b] = (u.vd_type[b] == BODY_ACTIVE)
                || (u.vd_type[b] == TAIL && u.ignore_vta)
                || (u.vd_type[b] == BODY_INACTIVE && u.ignore_vma);
        end
        return s;
    endfunction

    function automatic ROB2RT_t make_vrf(input logic [4:0] idx, input logic [VLEN-1:0] data);
        ROB2RT_t u;
        u = '0;
        u.w_valid = 1'b1;
        u.w_index = idx;
        u.w_data  = data;
        u.w_type  = VRF;
        for (int b = 0; b < VLENB; b++) u.vd_type[b] = BODY_ACTIVE;
        return u;
    endfunction

    function automatic ROB2RT_t rand_uop();
        ROB2RT_t u;
        logic [31:0] r;
        r = $urandom;
        u = '0;
        u.w_valid        = (r[1:0] != 2'd0);
        u.w_index        = {2'b00, r[4:2]};
        u.w_type         = (r[6:5] == 2'd0) ? XRF : VRF;
        u.trap_flag      = (r[10:7] == 4'd0);
        u.vxsat          = r[11];
        u.ignore_vta     = r[12];
        u.ignore_vma     = r[13];
        u.last_uop_valid = r[14];
        u.w_data         = {$urandom, $urandom, $urandom, $urandom};
        r = $urandom;
        u.vector_csr     = r[$bits(RVVCSR_t)-1:0];
        r = $urandom;
        for (int b = 0; b < VLENB; b++) u.vd_type[b] = byte_type_e'(r[2*b +: 2]);
        return u;
    endfunction

    task automatic model_reset();
        m_trap = 0; m_vv = '0; m_v = '0; m_xv = 0; m_x = '0;
        m_vxsat = 0; m_vcsr_v = 0; m_vcsr = '0;
    endtask

    // One clock cycle: inputs are already driven; starts and ends at a falling edge.
    task automatic run_cycle();
        bit drain, open, exp_done, n_vxsat, n_vcsr_v;
        logic [NUM_RT_UOP-1:0] exp_ready, nvv;
        RT2VRF_t [NUM_RT_UOP-1:0] nv;
        bit nxv;
        RT2XRF_t nx;
        int n;
        bit n_trap;
        drain = ((m_vv == '0) || wr_ready_vrf) && (!m_xv || wr_ready_xrf);
        open  = !m_trap && drain;
        exp_ready = '0;
        n = 0;
        if (open) begin
            for (int i = 0; i < NUM_RT_UOP; i++) begin
                if (i > 0 && rob[i].w_type == XRF) break;
                exp_ready[i] = 1'b1;
                if (!rd_valid[i]) break;
                n = i + 1;
                if (rob[i].trap_flag || rob[i].w_type == XRF) break;
            end
        end
        exp_done = m_trap && drain;
        #1;
        last_ready = rd_ready;
        if (trap_done_rvv2rvs === 1'b1) done_pulses++;
        checks++;
        if (rd_ready !== exp_ready) begin
            errors++;
            $display("FAIL rd_ready: got %b expected %b", rd_ready, exp_ready);
        end
        checks++;
        if (trap_done_rvv2rvs !== exp_done) begin
            errors++;
            $display("FAIL trap_done: got %b expected %b", trap_done_rvv2rvs, exp_done);
        end

        nvv = '0; nv = '0; nxv = 0; nx = '0; n_vxsat = 0; n_vcsr_v = 0; n_trap = 0;
        for (int i = 0; i < n; i++) begin
            if (rob[i].trap_flag) n_trap = 1;
            if (rob[i].w_valid && rob[i].vxsat) n_vxsat = 1;
            if (rob[i].last_uop_valid) begin
                n_vcsr_v = 1;
                m_vcsr   = rob[i].vector_csr;
            end
            if (rob[i].w_valid && !rob[i].trap_flag) begin
                if (rob[i].w_type == VRF) begin
                    nvv[i] = 1'b1;
                    nv[i].rt_index  = rob[i].w_index;
                    nv[i].rt_data   = rob[i].w_data;
                    nv[i].rt_strobe = strobe_of(rob[i]);
                end else begin
                    nxv = 1;
                    nx.rt_index = rob[i].w_index;
                    nx.rt_data  = rob[i].w_data[31:0];
                end
            end
        end
        for (int i = 0; i < NUM_RT_UOP; i++)
            for (int j = i + 1; j < NUM_RT_UOP; j++)
                if (nvv[i] && nvv[j] && nv[i].rt_index == nv[j].rt_index)
                    nv[i].rt_strobe = nv[i].rt_strobe & ~nv[j].rt_strobe;
        if (drain) begin
            m_vv = nvv; m_v = nv; m_xv = nxv; m_x = nx;
        end
        m_trap   = m_trap ? !drain : n_trap;
        m_vxsat  = n_vxsat;
        m_vcsr_v = n_vcsr_v;

        @(posedge clk);
        #1;
        checks++;
        if (wr_valid_rt2vrf !== m_vv) begin
            errors++;
            $display("FAIL vrf_valid: got %b expected %b", wr_valid_rt2vrf, m_vv);
        end
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            if (m_vv[i]) begin
                checks++;
                if (wr_rt2vrf[i] !== m_v[i]) begin
                    errors++;
                    $display("FAIL vrf_lane%0d: got %h expected %h", i, wr_rt2vrf[i], m_v[i]);
                end
            end
        end
        checks++;
        if (wr_valid_rt2xrf !== m_xv || (m_xv && wr_rt2xrf !== m_x)) begin
            errors++;
            $display("FAIL xrf: got %b/%h expected %b/%h", wr_valid_rt2xrf, wr_rt2xrf, m_xv, m_x);
        end
        checks++;
        if (vxsat_valid_rt2csr !== m_vxsat) begin
            errors++;
            $display("FAIL vxsat: got %b expected %b", vxsat_valid_rt2csr, m_vxsat);
        end
        checks++;
        if (vcsr_valid_rt2csr !== m_vcsr_v || (m_vcsr_v && vcsr_rt2csr !== m_vcsr)) begin
            errors++;
            $display("FAIL vcsr: got %b/%h expected %b/%h", vcsr_valid_rt2csr, vcsr_rt2csr, m_vcsr_v, m_vcsr);
        end
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int cnt);
        rd_valid = '0; wr_ready_vrf = 1'b1; wr_ready_xrf = 1'b1;
        for (int k = 0; k < cnt; k++) run_cycle();
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (rd_ready !== '0 || wr_valid_rt2vrf !== '0 || wr_rt2vrf !== '0 || wr_valid_rt2xrf !== 1'b0
            || vxsat_valid_rt2csr !== 1'b0 || vcsr_valid_rt2csr !== 1'b0 || trap_done_rvv2rvs !== 1'b0) begin
            errors++;
            $display("FAIL %s: got ready=%b vrf=%b xrf=%b vxsat=%b vcsr=%b done=%b expected all 0", tag,
                     rd_ready, wr_valid_rt2vrf, wr_valid_rt2xrf, vxsat_valid_rt2csr, vcsr_valid_rt2csr,
                     trap_done_rvv2rvs);
        end
    endtask

    task automatic test_reset();
        rd_valid = 4'hF;
        for (int i = 0; i < NUM_RT_UOP; i++) rob[i] = make_vrf(5'(i), '1);
        #2;
        check_all_zero("reset_state");
        @(negedge clk);
        rd_valid = '0;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_four_lanes();
        for (int i = 0; i < NUM_RT_UOP; i++) rob[i] = make_vrf(5'(i + 1), {$urandom, $urandom, $urandom, $urandom});
        rd_valid = 4'hF; wr_ready_vrf = 1'b1;
        run_cycle();
        checks++;
        if (last_ready !== 4'hF || wr_valid_rt2vrf !== 4'hF) begin
            errors++;
            $display("FAIL four_lanes: got ready=%b valid=%b expected 1111/1111", last_ready, wr_valid_rt2vrf);
        end
        for (int i = 0; i < NUM_RT_UOP; i++) begin
            checks++;
            if (wr_rt2vrf[i].rt_strobe !== 16'hFFFF || wr_rt2vrf[i].rt_index !== 5'(i + 1)) begin
                errors++;
                $display("FAIL four_lanes_strobe%0d: got %h/%0d expected ffff/%0d", i,
                         wr_rt2vrf[i].rt_strobe, wr_rt2vrf[i].rt_index, i + 1);
            end
        end
        idle_cycles(1);
    endtask

    task automatic test_overlap();
        rob[0] = make_vrf(5'd5, {4{32'h1111_2222}});
        rob[1] = make_vrf(5'd5, {4{32'h3333_4444}});
        for (int b = 8; b < VLENB; b++) rob[1].vd_type[b] = BODY_INACTIVE;
        rd_valid = 4'b0011;
        run_cycle();
        checks++;
        if (wr_rt2vrf[0].rt_strobe !== 16'hFF00 || wr_rt2vrf[1].rt_strobe !== 16'h00FF) begin
            errors++;
            $display("FAIL overlap_strobe: got %h/%h expected ff00/00ff",
                     wr_rt2vrf[0].rt_strobe, wr_rt2vrf[1].rt_strobe);
        end
        idle_cycles(1);
    endtask

    task automatic test_xrf();
        ROB2RT_t x;
        x = make_vrf(5'd9, {$urandom, $urandom, $urandom, $urandom});
        x.w_type = XRF;
        rob[0] = make_vrf(5'd7, '1);
        rob[1] = x;
        rob[2] = make_vrf(5'd3, '0);
        rd_valid = 4'b0111;
        run_cycle();
        checks++;
        if (last_ready !== 4'b0001) begin
            errors++;
            $display("FAIL xrf_split_ready: got %b expected 0001", last_ready);
        end
        rob[0] = x;
        rob[1] = make_vrf(5'd3, '0);
        rd_valid = 4'b0011;
        run_cycle();
        checks++;
        if (last_ready !== 4'b0001 || wr_valid_rt2xrf !== 1'b1 || wr_rt2xrf.rt_data !== x.w_data[31:0]
            || wr_rt2xrf.rt_index !== 5'd9) begin
            errors++;
            $display("FAIL xrf_write: got ready=%b v=%b data=%h idx=%0d expected 0001/1/%h/9",
                     last_ready, wr_valid_rt2xrf, wr_rt2xrf.rt_data, wr_rt2xrf.rt_index, x.w_data[31:0]);
        end
        idle_cycles(1);
    endtask

    task automatic test_trap();
        for (int i = 0; i < NUM_RT_UOP; i++) rob[i] = make_vrf(5'(i + 1), {4{$urandom}});
        rob[1].trap_flag = 1'b1;
        rd_valid = 4'hF;
        run_cycle();
        checks++;
        if (last_ready !== 4'b0011 || wr_valid_rt2vrf !== 4'b0001) begin
            errors++;
            $display("FAIL trap_accept: got ready=%b vrf=%b expected 0011/0001", last_ready, wr_valid_rt2vrf);
        end
        done_pulses = 0;
        rob[1].trap_flag = 1'b0;
        wr_ready_vrf = 1'b0;
        run_cycle();
        wr_ready_vrf = 1'b1;
        run_cycle();
        rd_valid = '0;
        run_cycle();
        run_cycle();
        checks++;
        if (done_pulses !== 1) begin
            errors++;
            $display("FAIL trap_done_count: got %0d expected 1", done_pulses);
        end
    endtask

    task automatic test_stall();
        RT2VRF_t [NUM_RT_UOP-1:0] snap;
        logic [VLEN-1:0] new_data;
        for (int i = 0; i < NUM_RT_UOP; i++) rob[i] = make_vrf(5'(i + 10), {4{$urandom}});
        rd_valid = 4'hF; wr_ready_vrf = 1'b1;
        run_cycle();
        snap = wr_rt2vrf;
        new_data = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < NUM_RT_UOP; i++) rob[i] = make_vrf(5'(i + 20), new_data);
        wr_ready_vrf = 1'b0;
        for (int k = 0; k < 3; k++) begin
            run_cycle();
            checks++;
            if (last_ready !== 4'h0 || wr_rt2vrf !== snap || wr_valid_rt2vrf !== 4'hF) begin
                errors++;
                $display("FAIL stall_hold%0d: got ready=%b valid=%b expected 0000/1111 and stable data",
                         k, last_ready, wr_valid_rt2vrf);
            end
        end
        wr_ready_vrf = 1'b1;
        run_cycle();
        checks++;
        if (last_ready !== 4'hF || wr_rt2vrf[0].rt_data !== new_data || wr_rt2vrf[0].rt_index !== 5'd20) begin
            errors++;
            $display("FAIL stall_release: got ready=%b idx=%0d expected 1111/20", last_ready, wr_rt2vrf[0].rt_index);
        end
        idle_cycles(1);
    endtask

    task automatic test_reset_mid();
        int vxsat_seen;
        rob[0] = make_vrf(5'd2, '1);
        rob[0].vxsat = 1'b1;
        rob[1] = make_vrf(5'd3, '1);
        rob[1].trap_flag = 1'b1;
        rd_valid = 4'b0011; wr_ready_vrf = 1'b0;
        run_cycle();
        rd_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        wr_ready_vrf = 1'b1;
        model_reset();
        done_pulses = 0;
        vxsat_seen = 0;
        for (int k = 0; k < 3; k++) begin
            run_cycle();
            if (vxsat_valid_rt2csr === 1'b1) vxsat_seen++;
        end
        checks++;
        if (done_pulses !== 0 || vxsat_seen !== 0) begin
            errors++;
            $display("FAIL reset_release_pulse: got done=%0d vxsat=%0d expected 0/0", done_pulses, vxsat_seen);
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int k = 0; k < 400; k++) begin
            r = $urandom;
            rd_valid     = r[3:0];
            wr_ready_vrf = (r[5:4] != 2'd0);
            wr_ready_xrf = (r[7:6] != 2'd0);
            for (int i = 0; i < NUM_RT_UOP; i++) rob[i] = rand_uop();
            run_cycle();
        end
        idle_cycles(3);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_four_lanes();
        test_overlap();
        test_xrf();
        test_trap();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
